// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory arbiter: memory command
// encodings, tag geometry, requester identities and the store classifier.
package mem_arbiter_pkg;

   localparam int TAG_W    = 4;
   localparam int NUM_TAGS = 16;

   localparam logic [3:0] MEM_NONE = 4'd0;
   localparam logic [3:0] MEM_LB   = 4'd1;
   localparam logic [3:0] MEM_LH   = 4'd2;
   localparam logic [3:0] MEM_LW   = 4'd3;
   localparam logic [3:0] MEM_LBU  = 4'd4;
   localparam logic [3:0] MEM_LHU  = 4'd5;
   localparam logic [3:0] MEM_SB   = 4'd6;
   localparam logic [3:0] MEM_SH   = 4'd7;
   localparam logic [3:0] MEM_SW   = 4'd8;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_DM = 1'b1;

   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_IF   = 2'd1,
      SEL_DM   = 2'd2
   } sel_e;

   function automatic logic mem_is_store(input logic [3:0] cmd);
      return (cmd == MEM_SB) || (cmd == MEM_SH) || (cmd == MEM_SW);
   endfunction

endpackage

// File: rtl/mem_tag_table.sv
// Outstanding-load bookkeeping: per-tag valid/owner, owner lookup for the
// completing tag, and per-requester outstanding counters.
module mem_tag_table
   import mem_arbiter_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             alloc_en,
   input  logic [TAG_W-1:0] alloc_tag,
   input  logic             alloc_owner,
   input  logic [TAG_W-1:0] cpl_tag,
   output logic             cpl_hit,
   output logic             cpl_owner,
   output logic [3:0]       if_out,
   output logic [3:0]       dm_out
);

   logic [NUM_TAGS-1:0] valid;
   logic [NUM_TAGS-1:0] owner;
   logic                if_inc, if_dec, dm_inc, dm_dec;

   // Tag 0 is never allocated, so valid[0] stays clear and tag 0 never hits.
   assign cpl_hit   = (cpl_tag != '0) && valid[cpl_tag];
   assign cpl_owner = owner[cpl_tag];

   assign if_inc = alloc_en && (alloc_owner == OWN_IF);
   assign dm_inc = alloc_en && (alloc_owner == OWN_DM);
   assign if_dec = cpl_hit && (cpl_owner == OWN_IF);
   assign dm_dec = cpl_hit && (cpl_owner == OWN_DM);

   // Free before allocate so a tag completing and re-issued in one cycle stays valid.
   always_ff @(posedge clk) begin
      if (!rst) begin
         valid  <= '0;
         if_out <= '0;
         dm_out <= '0;
      end else begin
         if (cpl_hit)
            valid[cpl_tag] <= 1'b0;
         if (alloc_en)
            valid[alloc_tag] <= 1'b1;
         if_out <= if_out + {3'b000, if_inc} - {3'b000, if_dec};
         dm_out <= dm_out + {3'b000, dm_inc} - {3'b000, dm_dec};
      end
   end

   always_ff @(posedge clk) begin
      if (alloc_en)
         owner[alloc_tag] <= alloc_owner;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one tagged single-ported memory between instruction fetch and the
// data port: fixed data priority with a fetch starvation guard, tag routing.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int MAX_STARVE = 4,
   parameter int MAX_OUT    = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_grant,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic [3:0]  dm_cmd,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic        dm_grant,
   output logic        dm_rvalid,
   output logic [31:0] dm_rdata,
   output logic [3:0]  proc2mem_command,
   output logic [31:0] proc2mem_addr,
   output logic [31:0] proc2mem_data,
   input  logic [3:0]  mem2proc_response,
   input  logic [31:0] mem2proc_data,
   input  logic [3:0]  mem2proc_tag,
   output logic        tag_err
);

   localparam int            SC_W         = (MAX_STARVE < 1) ? 1 : $clog2(MAX_STARVE + 1);
   localparam logic [SC_W-1:0] STARVE_LIMIT = SC_W'(MAX_STARVE);
   localparam logic [3:0]    OUT_LIMIT    = 4'(MAX_OUT);

   sel_e            sel;
   logic            data_ok, if_ok, dm_store;
   logic            alloc_en, alloc_owner;
   logic            cpl_hit, cpl_owner;
   logic [3:0]      cpl_tag;
   logic [3:0]      if_out, dm_out;
   logic [SC_W-1:0] starve_cnt;

   mem_tag_table u_tags (
      .clk         (clk),
      .rst         (rst),
      .alloc_en    (alloc_en),
      .alloc_tag   (mem2proc_response),
      .alloc_owner (alloc_owner),
      .cpl_tag     (cpl_tag),
      .cpl_hit     (cpl_hit),
      .cpl_owner   (cpl_owner),
      .if_out      (if_out),
      .dm_out      (dm_out)
   );

   always_comb begin
      dm_store = mem_is_store(dm_cmd);
      data_ok  = (dm_cmd != MEM_NONE) && (dm_store || (dm_out < OUT_LIMIT));
      if_ok    = if_req && (if_out < OUT_LIMIT);

      sel = SEL_NONE;
      if (rst) begin
         if (data_ok && !((starve_cnt == STARVE_LIMIT) && if_ok))
            sel = SEL_DM;
         else if (if_ok)
            sel = SEL_IF;
      end

      proc2mem_command = MEM_NONE;
      proc2mem_addr    = '0;
      proc2mem_data    = '0;
      case (sel)
         SEL_IF: begin
            proc2mem_command = MEM_LW;
            proc2mem_addr    = if_addr;
         end
         SEL_DM: begin
            proc2mem_command = dm_cmd;
            proc2mem_addr    = dm_addr;
            proc2mem_data    = dm_wdata;
         end
         default: ;
      endcase

      if_grant    = (sel == SEL_IF) && (mem2proc_response != '0);
      dm_grant    = (sel == SEL_DM) && (mem2proc_response != '0);
      alloc_en    = if_grant || (dm_grant && !dm_store);
      alloc_owner = dm_grant ? OWN_DM : OWN_IF;

      // Completions are ignored while reset is held.
      cpl_tag   = rst ? mem2proc_tag : '0;
      if_rvalid = cpl_hit && (cpl_owner == OWN_IF);
      dm_rvalid = cpl_hit && (cpl_owner == OWN_DM);
      if_rdata  = if_rvalid ? mem2proc_data : '0;
      dm_rdata  = dm_rvalid ? mem2proc_data : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst)
         starve_cnt <= '0;
      else if (if_grant || !if_req)
         starve_cnt <= '0;
      else if (if_ok && (starve_cnt != STARVE_LIMIT))
         starve_cnt <= starve_cnt + SC_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst)
         tag_err <= 1'b0;
      else if ((mem2proc_tag != '0) && !cpl_hit)
         tag_err <= 1'b1;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a tag-map reference model.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int MAX_STARVE = 4;
   localparam int MAX_OUT    = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_grant, if_rvalid, dm_grant, dm_rvalid, tag_err;
   logic [31:0] if_rdata, dm_rdata, proc2mem_addr, proc2mem_data;
   logic [3:0]  dm_cmd = MEM_NONE;
   logic [31:0] dm_addr = '0, dm_wdata = '0;
   logic [3:0]  proc2mem_command;
   logic [3:0]  mem2proc_response = '0;
   logic [31:0] mem2proc_data = '0;
   logic [3:0]  mem2proc_tag = '0;

   mem_arbiter #(.MAX_STARVE(MAX_STARVE), .MAX_OUT(MAX_OUT)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_grant(if_grant),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_cmd(dm_cmd), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_grant(dm_grant), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
      .proc2mem_data(proc2mem_data), .mem2proc_response(mem2proc_response),
      .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
      .tag_err(tag_err)
   );

   always #5 clk = ~clk;

   // Reference model: which tags are outstanding and who owns them.
   bit m_valid[16];
   bit m_owner[16];
   int m_starve = 0;
   bit m_tag_err = 1'b0;

   int n_checks = 0;
   int n_err = 0;

   bit e_ig, e_dg, e_iok, e_store;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic int m_count(input bit own);
      int c = 0;
      for (int t = 1; t < 16; t++)
         if (m_valid[t] && m_owner[t] == own) c++;
      return c;
   endfunction

   task automatic eval();
      int ic, dc, sel;
      bit dok, hit;
      logic [3:0] ecmd;
      logic [31:0] eaddr, edata;
      #1;
      ic = m_count(1'b0);
      dc = m_count(1'b1);
      e_store = (dm_cmd == MEM_SB) || (dm_cmd == MEM_SH) || (dm_cmd == MEM_SW);
      dok   = (dm_cmd != MEM_NONE) && (e_store || dc < MAX_OUT);
      e_iok = if_req && (ic < MAX_OUT);
      sel = 0;
      if (rst) begin
         if (dok && !(m_starve == MAX_STARVE && e_iok)) sel = 2;
         else if (e_iok) sel = 1;
      end
      ecmd  = (sel == 2) ? dm_cmd : (sel == 1) ? MEM_LW : MEM_NONE;
      eaddr = (sel == 2) ? dm_addr : (sel == 1) ? if_addr : 32'h0;
      edata = (sel == 2) ? dm_wdata : 32'h0;
      e_ig = (sel == 1) && (mem2proc_response != 0);
      e_dg = (sel == 2) && (mem2proc_response != 0);
      hit  = rst && (mem2proc_tag != 0) && m_valid[mem2proc_tag];
      chk("if_grant", if_grant, e_ig);
      chk("dm_grant", dm_grant, e_dg);
      chk("cmd", proc2mem_command, ecmd);
      chk("addr", proc2mem_addr, eaddr);
      chk("wdata", proc2mem_data, edata);
      chk("if_rvalid", if_rvalid, hit && !m_owner[mem2proc_tag]);
      chk("dm_rvalid", dm_rvalid, hit && m_owner[mem2proc_tag]);
      chk("if_rdata", if_rdata, (hit && !m_owner[mem2proc_tag]) ? mem2proc_data : 32'h0);
      chk("dm_rdata", dm_rdata, (hit && m_owner[mem2proc_tag]) ? mem2proc_data : 32'h0);
      chk("tag_err", tag_err, m_tag_err);
   endtask

   task automatic adv();
      @(posedge clk);
      if (!rst) begin
         for (int t = 0; t < 16; t++) m_valid[t] = 1'b0;
         m_starve  = 0;
         m_tag_err = 1'b0;
      end else begin
         if (mem2proc_tag != 0) begin
            if (m_valid[mem2proc_tag]) m_valid[mem2proc_tag] = 1'b0;
            else m_tag_err = 1'b1;
         end
         if (e_ig) begin
            m_valid[mem2proc_response] = 1'b1;
            m_owner[mem2proc_response] = 1'b0;
         end
         if (e_dg && !e_store) begin
            m_valid[mem2proc_response] = 1'b1;
            m_owner[mem2proc_response] = 1'b1;
         end
         if (e_ig || !if_req) m_starve = 0;
         else if (e_iok && m_starve < MAX_STARVE) m_starve++;
      end
      @(negedge clk);
   endtask

   task automatic chk_counters(input string nm);
      chk({nm, "_if_out"}, 32'(dut.u_tags.if_out), 32'(m_count(1'b0)));
      chk({nm, "_dm_out"}, 32'(dut.u_tags.dm_out), 32'(m_count(1'b1)));
   endtask

   initial begin
      logic [3:0] cmds[8];
      int q[$];
      bit last_ig, last_dg;
      int t;
      cmds = '{MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW};
      for (int i = 0; i < 16; i++) begin m_valid[i] = 1'b0; m_owner[i] = 1'b0; end

      // Reset with requests pending: nothing may be issued.
      if_req = 1'b1; if_addr = 32'h40; dm_cmd = MEM_LW; mem2proc_response = 4'd3;
      adv();
      eval();
      chk("rst_cmd", proc2mem_command, MEM_NONE);
      chk("rst_grant", if_grant | dm_grant, 1'b0);
      chk("rst_tag_err", tag_err, 1'b0);
      adv();

      // Fetch tag 3, completes two cycles later.
      rst = 1'b1; dm_cmd = MEM_NONE;
      eval();
      chk("t1_grant", if_grant, 1'b1);
      chk("t1_cmd", proc2mem_command, MEM_LW);
      chk("t1_addr", proc2mem_addr, 32'h40);
      adv();
      if_req = 1'b0; mem2proc_response = 0;
      eval(); adv();
      mem2proc_tag = 4'd3; mem2proc_data = 32'hDEADBEEF;
      eval();
      chk("t1_rvalid", if_rvalid, 1'b1);
      chk("t1_rdata", if_rdata, 32'hDEADBEEF);
      chk("t1_dm_rvalid", dm_rvalid, 1'b0);
      adv();
      mem2proc_tag = 0;

      // Both requesting continuously: four data grants, then one fetch.
      for (int i = 0; i < 10; i++) begin
         if_req = 1'b1; if_addr = 32'h1000; dm_cmd = MEM_LW; dm_addr = 32'h2000;
         mem2proc_response = 4'((i % 4) + 1);
         mem2proc_tag = (i == 0) ? 4'd0 : 4'(((i - 1) % 4) + 1);
         mem2proc_data = 32'(i);
         eval();
         chk("t2_dm_grant", dm_grant, (i % 5) != 4);
         chk("t2_if_grant", if_grant, (i % 5) == 4);
         adv();
      end
      if_req = 1'b0; dm_cmd = MEM_NONE; mem2proc_response = 0; mem2proc_tag = 4'd2;
      eval(); adv();
      mem2proc_tag = 0;
      eval();
      chk("t2_if_out", 32'(dut.u_tags.if_out), 32'd0);
      chk("t2_dm_out", 32'(dut.u_tags.dm_out), 32'd0);
      adv();

      // Store: granted, no table entry.
      dm_cmd = MEM_SW; dm_addr = 32'h100; dm_wdata = 32'h1234; mem2proc_response = 4'd5;
      eval();
      chk("t3_grant", dm_grant, 1'b1);
      chk("t3_data", proc2mem_data, 32'h1234);
      chk("t3_cmd", proc2mem_command, MEM_SW);
      adv();
      dm_cmd = MEM_NONE; mem2proc_response = 0;
      eval();
      chk("t3_dm_out", 32'(dut.u_tags.dm_out), 32'd0);
      adv();

      // Data tag 2 and fetch tag 7 outstanding; complete 7 then 2.
      dm_cmd = MEM_LW; dm_addr = 32'h200; mem2proc_response = 4'd2;
      eval(); chk("t4_dm_grant", dm_grant, 1'b1); adv();
      dm_cmd = MEM_NONE; if_req = 1'b1; if_addr = 32'h300; mem2proc_response = 4'd7;
      eval(); chk("t4_if_grant", if_grant, 1'b1); adv();
      if_req = 1'b0; mem2proc_response = 0; mem2proc_tag = 4'd7; mem2proc_data = 32'h77;
      eval();
      chk("t4_if_rvalid", if_rvalid, 1'b1);
      chk("t4_if_rdata", if_rdata, 32'h77);
      chk("t4_dm_rvalid0", dm_rvalid, 1'b0);
      adv();
      mem2proc_tag = 4'd2; mem2proc_data = 32'h22;
      eval();
      chk("t4_dm_rvalid", dm_rvalid, 1'b1);
      chk("t4_dm_rdata", dm_rdata, 32'h22);
      adv();
      mem2proc_tag = 0;
      eval(); chk_counters("t4"); adv();

      // Fetch outstanding limit of two.
      if_req = 1'b1; if_addr = 32'h500; mem2proc_response = 4'd1;
      eval(); chk("t5_g1", if_grant, 1'b1); adv();
      mem2proc_response = 4'd2;
      eval(); chk("t5_g2", if_grant, 1'b1); adv();
      mem2proc_response = 4'd3;
      eval();
      chk("t5_g3_blocked", if_grant, 1'b0);
      chk("t5_cmd_none", proc2mem_command, MEM_NONE);
      adv();
      mem2proc_tag = 4'd1; mem2proc_data = 32'h11;
      eval();
      chk("t5_still_blocked", if_grant, 1'b0);
      chk("t5_rvalid", if_rvalid, 1'b1);
      adv();
      mem2proc_tag = 0;
      eval(); chk("t5_g3", if_grant, 1'b1); adv();
      if_req = 1'b0; mem2proc_response = 0; mem2proc_tag = 4'd2;
      eval(); adv();
      mem2proc_tag = 4'd3;
      eval(); adv();
      mem2proc_tag = 0;
      eval(); chk_counters("t5"); adv();

      // Completion and re-allocation of tag 6 in the same cycle.
      if_req = 1'b1; mem2proc_response = 4'd6;
      eval(); adv();
      if_req = 1'b0; dm_cmd = MEM_LW; dm_addr = 32'h600; mem2proc_tag = 4'd6; mem2proc_data = 32'h66;
      eval();
      chk("t7_if_rvalid", if_rvalid, 1'b1);
      chk("t7_dm_grant", dm_grant, 1'b1);
      adv();
      dm_cmd = MEM_NONE; mem2proc_response = 0; mem2proc_data = 32'h99;
      eval();
      chk("t7_dm_rvalid", dm_rvalid, 1'b1);
      chk("t7_dm_rdata", dm_rdata, 32'h99);
      adv();
      mem2proc_tag = 0;

      // Reset with tag 4 outstanding; stale completion flags tag_err.
      if_req = 1'b1; mem2proc_response = 4'd4;
      eval(); adv();
      if_req = 1'b0; mem2proc_response = 0; rst = 1'b0;
      eval(); adv();
      rst = 1'b1; mem2proc_tag = 4'd4; mem2proc_data = 32'h44;
      eval(); chk("t6_no_rvalid", if_rvalid | dm_rvalid, 1'b0); adv();
      mem2proc_tag = 0;
      eval(); chk("t6_tag_err", tag_err, 1'b1); adv();
      rst = 1'b0;
      eval(); adv();
      rst = 1'b1;
      eval(); chk("t6_tag_err_clr", tag_err, 1'b0); adv();

      // Randomized traffic.
      last_ig = 1'b0; last_dg = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rst = ($urandom_range(99) != 0);
         if (!if_req || last_ig) begin
            if_req  = $urandom_range(1);
            if_addr = $urandom;
         end
         if (dm_cmd == MEM_NONE || last_dg) begin
            dm_cmd   = ($urandom_range(1) == 0) ? MEM_NONE : cmds[$urandom_range(7)];
            dm_addr  = $urandom;
            dm_wdata = $urandom;
         end
         mem2proc_tag = 0;
         q.delete();
         for (int k = 1; k < 16; k++) if (m_valid[k]) q.push_back(k);
         if ($urandom_range(99) < 45 && q.size() > 0)
            mem2proc_tag = 4'(q[$urandom_range(q.size() - 1)]);
         else if ($urandom_range(99) < 2) begin
            t = $urandom_range(15, 1);
            if (!m_valid[t]) mem2proc_tag = 4'(t);
         end
         mem2proc_data = $urandom;
         mem2proc_response = 0;
         if ($urandom_range(99) < 75) begin
            for (int k = 0; k < 32; k++) begin
               t = $urandom_range(15, 1);
               if (!m_valid[t] || t == int'(mem2proc_tag)) begin
                  mem2proc_response = 4'(t);
                  break;
               end
            end
         end
         eval();
         last_ig = e_ig; last_dg = e_dg;
         adv();
      end
      rst = 1'b1; if_req = 1'b0; dm_cmd = MEM_NONE; mem2proc_response = 0; mem2proc_tag = 0;
      eval(); chk_counters("rand"); adv();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
